cam_frame_capture: RTL

Parametrised camera capture engine, successor to the fixed 640x480 RGB444 capture path. It runs entirely in the camera pixel-clock domain and pairs OV7670 bytes into pixels of configurable width. It crops a configurable window, decimates by 1/2/4 at run time, supports single-shot or continuous capture, and emits linear BRAM write transactions with frame status. It sits between the camera pins and the frame-buffer BRAM, gated by the camera-init `cam_done` flag.

---
 rtl/cam_frame_capture.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cam_frame_capture.sv
// cam_frame_capture: pairs camera bytes into pixels, crops and decimates, emits linear BRAM writes
module cam_frame_capture #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned X0       = 0,
    parameter int unsigned Y0       = 0,
    parameter int unsigned WIN_W    = 640,
    parameter int unsigned WIN_H    = 480,
    parameter int unsigned PIX_W    = 12,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_done,
    input  logic              arm,
    input  logic              continuous,
    input  logic              stop,
    input  logic [1:0]        scale,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic              pix_wr,
    output logic [PIX_W-1:0]  pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              line_err
);
    localparam int unsigned XW   = $clog2(H_ACTIVE + 2);
    localparam int unsigned YW   = $clog2(V_ACTIVE + 1);
    localparam int unsigned AREA = WIN_W * WIN_H;

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d, stop_q, stop_d, vs_q, hr_q, phase_q, phase_d;
    logic [2:0]        step_q, step_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [7:0]        b0_q, b0_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_max;
    logic              pix_wr_q, pix_wr_d, frame_done_q, frame_done_d;
    logic              busy_q, busy_d, line_err_q, line_err_d;
    logic [PIX_W-1:0]  pix_data_q, pix_data_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [31:0]       xr, yr;
    logic              in_win;

    assign pix_wr     = pix_wr_q;
    assign pix_data   = pix_data_q;
    assign pix_addr   = pix_addr_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign line_err   = line_err_q;

    // Next-state logic: mode control, byte pairing, window/decimation test and address generation
    always_comb begin
        xr           = 32'(x_q) - X0;
        yr           = 32'(y_q) - Y0;
        in_win       = xr < WIN_W && yr < WIN_H && (xr & (32'(step_q) - 1)) == 0 && (yr & (32'(step_q) - 1)) == 0;
        addr_max     = ADDR_W'(step_q == 3'd1 ? AREA - 1 : step_q == 3'd2 ? AREA / 4 - 1 : AREA / 16 - 1);
        state_d      = state_q;
        mode_d       = mode_q;
        stop_d       = stop_q | stop;
        step_d       = step_q;
        x_d          = x_q;
        y_d          = y_q;
        phase_d      = phase_q;
        b0_d         = b0_q;
        addr_d       = addr_q;
        pix_wr_d     = 1'b0;
        pix_data_d   = pix_data_q;
        pix_addr_d   = pix_addr_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        line_err_d   = line_err_q;
        case (state_q)
            IDLE: begin
                if (arm && cam_done) begin
                    mode_d     = continuous;
                    line_err_d = 1'b0;
                    state_d    = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vs_q && !vsync) begin
                    step_d  = scale == 2'd0 ? 3'd1 : scale == 2'd1 ? 3'd2 : 3'd4;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                    addr_d  = '0;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (href) begin
                    phase_d = ~phase_q;
                    b0_d    = phase_q ? b0_q : d;
                    if (phase_q) begin
                        x_d = x_q == XW'(H_ACTIVE + 1) ? x_q : x_q + 1'b1;
                        if (in_win) begin
                            pix_wr_d   = 1'b1;
                            pix_data_d = PIX_W'({b0_q, d});
                            pix_addr_d = addr_q;
                            addr_d     = addr_q == addr_max ? addr_q : addr_q + 1'b1;
                        end
                    end
                end
                if (hr_q && !href) begin
                    line_err_d = line_err_q | (x_q != XW'(H_ACTIVE));
                    x_d        = '0;
                    phase_d    = 1'b0;
                    y_d        = y_q == YW'(V_ACTIVE) ? y_q : y_q + 1'b1;
                end
                if (!vs_q && vsync) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    state_d      = (mode_q && !(stop_q || stop)) ? WAIT_VS : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!cam_done) begin
            state_d      = IDLE;
            pix_wr_d     = 1'b0;
            frame_done_d = 1'b0;
            frame_cnt_d  = frame_cnt_q;
        end
        if (state_d == IDLE && state_q != IDLE) stop_d = 1'b0;
        busy_d = state_d != IDLE;
    end

    // Register all state and outputs; edge detectors keep last cycle's vsync/href
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            stop_q       <= 1'b0;
            vs_q         <= 1'b0;
            hr_q         <= 1'b0;
            phase_q      <= 1'b0;
            step_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            b0_q         <= '0;
            addr_q       <= '0;
            pix_wr_q     <= 1'b0;
            pix_data_q   <= '0;
            pix_addr_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            stop_q       <= stop_d;
            vs_q         <= vsync;
            hr_q         <= href;
            phase_q      <= phase_d;
            step_q       <= step_d;
            x_q          <= x_d;
            y_q          <= y_d;
            b0_q         <= b0_d;
            addr_q       <= addr_d;
            pix_wr_q     <= pix_wr_d;
            pix_data_q   <= pix_data_d;
            pix_addr_q   <= pix_addr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            line_err_q   <= line_err_d;
        end
    end
endmodule
